// File: rtl/msg_event_scheduler_if.sv
// rtl/msg_event_scheduler_if.sv - requester and output-slot handshake bundle for msg_event_scheduler
interface msg_event_scheduler_if #(
    parameter int N  = 4,
    parameter int CW = 8,
    parameter int SW = $clog2(N + 1)
) ();
    logic [N-1:0]      req_valid;
    logic [2*N-1:0]    req_sev;
    logic [CW*N-1:0]   req_code;
    logic [N-1:0]      req_ack;
    logic              out_valid;
    logic              out_ready;
    logic [SW-1:0]     out_src;
    logic [1:0]        out_sev;
    logic [CW-1:0]     out_code;

    // Scheduler side: consumes requests, drives the output slot
    modport master (
        input  req_valid, req_sev, req_code, out_ready,
        output req_ack, out_valid, out_src, out_sev, out_code
    );

    // Environment side: requesters plus the downstream consumer
    modport slave (
        output req_valid, req_sev, req_code, out_ready,
        input  req_ack, out_valid, out_src, out_sev, out_code
    );
endinterface

// File: rtl/msg_event_scheduler.sv
// rtl/msg_event_scheduler.sv - round-robin severity event scheduler with filtering, counters, timeout and stop sequencing
module msg_event_scheduler #(
    parameter int N  = 4,
    parameter int CW = 8,
    parameter int SW = $clog2(N + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    msg_event_scheduler_if.master bus,
    input  logic [31:0]           i_cfg_error_limit,
    input  logic [31:0]           i_cfg_timeout,
    input  logic                  i_cfg_info_on,
    input  logic                  i_cfg_warn_on,
    output logic [31:0]           o_error_count,
    output logic [31:0]           o_warn_count,
    output logic                  o_error_flag,
    output logic                  o_fatal_flag,
    output logic                  o_timed_out,
    output logic                  o_stop
);
    localparam int PW = $clog2(N);

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_DRAIN   = 2'd1;
    localparam logic [1:0] ST_STOPPED = 2'd2;

    localparam logic [1:0] SEV_INFO  = 2'd0;
    localparam logic [1:0] SEV_WARN  = 2'd1;
    localparam logic [1:0] SEV_FATAL = 2'd3;

    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    logic [1:0]    r_state;
    logic [PW-1:0] r_ptr;
    logic [31:0]   r_cycle_cnt;
    logic          r_to_pend;
    logic          r_out_valid;
    logic [SW-1:0] r_out_src;
    logic [1:0]    r_out_sev;
    logic [CW-1:0] r_out_code;
    logic [31:0]   r_err_cnt;
    logic [31:0]   r_warn_cnt;
    logic          r_error_flag;
    logic          r_fatal_flag;
    logic          r_timed_out;

    logic [1:0]    w_sev_arr  [N];
    logic [CW-1:0] w_code_arr [N];
    logic          w_found;
    logic [PW-1:0] w_win;
    logic [PW-1:0] w_ptr_next;
    logic          w_run;
    logic          w_slot_free;
    logic          w_to_fire;
    logic          w_to_load;
    logic          w_grant;
    logic [1:0]    w_gsev;
    logic [CW-1:0] w_gcode;
    logic          w_pass;
    logic          w_warn_inc;
    logic          w_err_inc;
    logic [31:0]   w_err_next;
    logic [31:0]   w_warn_next;
    logic          w_trigger;
    logic [N-1:0]  w_ack;

    // Split the flat request buses into per-requester fields
    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_sev_arr[i]  = bus.req_sev[2*i +: 2];
            w_code_arr[i] = bus.req_code[CW*i +: CW];
        end
    end

    // Round-robin search: first pending requester at or after the pointer, wrapping
    always_comb begin
        logic [PW:0] v_sum;
        v_sum   = '0;
        w_found = 1'b0;
        w_win   = '0;
        for (int i = 0; i < N; i++) begin
            v_sum = {1'b0, r_ptr} + (PW+1)'(i);
            if (v_sum >= (PW+1)'(N)) begin
                v_sum = v_sum - (PW+1)'(N);
            end
            if (!w_found && bus.req_valid[v_sum[PW-1:0]]) begin
                w_found = 1'b1;
                w_win   = v_sum[PW-1:0];
            end
        end
    end

    assign w_ptr_next  = (w_win == PW'(N - 1)) ? '0 : w_win + PW'(1);
    assign w_run       = (r_state == ST_RUN);
    assign w_slot_free = !r_out_valid || bus.out_ready;

    // Timeout fires on the cycle the counter would reach the programmed value
    assign w_to_fire = w_run && (i_cfg_timeout != 32'd0) &&
                       ((r_cycle_cnt + 32'd1) == i_cfg_timeout);
    // The synthetic timeout event outranks every requester for a free slot
    assign w_to_load = w_slot_free && (r_to_pend || w_to_fire);
    assign w_grant   = w_run && w_slot_free && !w_to_load && w_found;

    assign w_gsev  = w_sev_arr[w_win];
    assign w_gcode = w_code_arr[w_win];

    // ERROR and FATAL always pass; INFO and WARN honour their enables
    assign w_pass = (w_gsev == SEV_INFO) ? i_cfg_info_on :
                    (w_gsev == SEV_WARN) ? i_cfg_warn_on : 1'b1;

    // A timeout and a grant can never coincide, so at most one error per cycle
    assign w_warn_inc  = w_grant && (w_gsev == SEV_WARN);
    assign w_err_inc   = (w_grant && w_gsev[1]) || w_to_fire;
    assign w_err_next  = (r_err_cnt == CNT_MAX) ? r_err_cnt : r_err_cnt + 32'd1;
    assign w_warn_next = (r_warn_cnt == CNT_MAX) ? r_warn_cnt : r_warn_cnt + 32'd1;

    // Stop trigger looks at the post-increment error count
    assign w_trigger = (w_grant && (w_gsev == SEV_FATAL)) || w_to_fire ||
                       ((i_cfg_error_limit != 32'd0) && w_err_inc &&
                        (w_err_next == i_cfg_error_limit));

    // Acks: one-hot winner while running, discard-all once stopping
    always_comb begin
        w_ack = '0;
        if (!w_run) begin
            w_ack = bus.req_valid;
        end else if (w_grant) begin
            w_ack[w_win] = 1'b1;
        end
    end

    assign bus.req_ack   = w_ack;
    assign bus.out_valid = r_out_valid;
    assign bus.out_src   = r_out_src;
    assign bus.out_sev   = r_out_sev;
    assign bus.out_code  = r_out_code;

    assign o_error_count = r_err_cnt;
    assign o_warn_count  = r_warn_cnt;
    assign o_error_flag  = r_error_flag;
    assign o_fatal_flag  = r_fatal_flag;
    assign o_timed_out   = r_timed_out;
    assign o_stop        = (r_state == ST_STOPPED);

    // Run / drain / stopped sequencing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_trigger) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_slot_free && !r_to_pend) begin
                        r_state <= ST_STOPPED;
                    end
                end
                default: r_state <= ST_STOPPED;
            endcase
        end
    end

    // Arbitration pointer advances past every granted requester, filtered or not
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_grant) begin
            r_ptr <= w_ptr_next;
        end
    end

    // Cycle counter runs only while in RUN with a timeout programmed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycle_cnt <= '0;
        end else if (w_run && (i_cfg_timeout != 32'd0)) begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
        end
    end

    // Remember a timeout that found the slot occupied
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_pend <= 1'b0;
        end else if (w_to_load) begin
            r_to_pend <= 1'b0;
        end else if (w_to_fire) begin
            r_to_pend <= 1'b1;
        end
    end

    // Output slot: load synthetic or granted event, otherwise empty on handoff
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_src   <= '0;
            r_out_sev   <= '0;
            r_out_code  <= '0;
        end else if (w_to_load) begin
            r_out_valid <= 1'b1;
            r_out_src   <= SW'(N);
            r_out_sev   <= SEV_FATAL;
            r_out_code  <= '0;
        end else if (w_grant && w_pass) begin
            r_out_valid <= 1'b1;
            r_out_src   <= SW'(w_win);
            r_out_sev   <= w_gsev;
            r_out_code  <= w_gcode;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Saturating counters and sticky flags; only RUN-cycle events reach here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_cnt    <= '0;
            r_warn_cnt   <= '0;
            r_error_flag <= 1'b0;
            r_fatal_flag <= 1'b0;
            r_timed_out  <= 1'b0;
        end else begin
            if (w_warn_inc) begin
                r_warn_cnt <= w_warn_next;
            end
            if (w_err_inc) begin
                r_err_cnt    <= w_err_next;
                r_error_flag <= 1'b1;
            end
            if (w_to_fire || (w_grant && (w_gsev == SEV_FATAL))) begin
                r_fatal_flag <= 1'b1;
            end
            if (w_to_fire) begin
                r_timed_out <= 1'b1;
            end
        end
    end
endmodule
